radix_8_ntt_ctrl: RTL and testbench

Sequencer that runs a full in-place 2^LOGP-point DIF NTT over GF(Q). It instantiates one combinational radix_8_dif_ntt butterfly and streams groups of 8 coefficients through it, one group per cycle, across LOGP/3 stages. For each group it drives element-index read/write requests to an external coefficient memory and twiddle-exponent requests to an external twiddle ROM. It sits between the top-level command interface (start/done) and the coefficient RAM.

---
 rtl/radix_8_ntt_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_radix_8_ntt_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_8_ntt_ctrl.sv
// radix_8_ntt_ctrl: in-place radix-8 DIF NTT sequencer. Define BITREV_OUT_EN to write the final stage in natural order.
module radix_8_dif_ntt #(
    parameter int N  = 17,
    parameter int Q  = 65537,
    parameter int W8 = 16
) (
    input  logic [8*N-1:0] a,
    input  logic [8*N-1:0] tf,
    output logic [8*N-1:0] y
);
    function automatic logic [N-1:0] mulmod(input logic [N-1:0] x, input logic [N-1:0] w);
        return N'((64'(x) * 64'(w)) % 64'(Q));
    endfunction
    function automatic logic [N-1:0] addmod(input logic [N-1:0] x, input logic [N-1:0] w);
        return N'((64'(x) + 64'(w)) % 64'(Q));
    endfunction
    function automatic logic [N-1:0] wpow(input int e);
        logic [N-1:0] r;
        r = N'(1);
        for (int i = 0; i < e; i++) r = mulmod(r, N'(W8));
        return r;
    endfunction
    logic [N-1:0] acc;
    // 8-point DFT over the group followed by the per-output twiddle multiply
    always_comb begin
        y = '0;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc = '0;
            for (int j = 0; j < 8; j++) acc = addmod(acc, mulmod(a[j*N +: N], wpow((j * k) % 8)));
            y[k*N +: N] = mulmod(acc, tf[k*N +: N]);
        end
    end
endmodule

module radix_8_ntt_ctrl #(
    parameter int N    = 17,
    parameter int Q    = 65537,
    parameter int LOGP = 6,
    parameter int W8   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [8*LOGP-1:0] rd_idx,
    input  logic [8*N-1:0]    rd_data,
    output logic [8*LOGP-1:0] tf_exp,
    input  logic [8*N-1:0]    tf_data,
    output logic              wr_en,
    output logic [8*LOGP-1:0] wr_idx,
    output logic [8*N-1:0]    wr_data
);
    localparam int POINTS = 1 << LOGP;
    localparam int GROUPS = POINTS / 8;
    localparam int STAGES = LOGP / 3;
    localparam int GW     = LOGP - 2;
    if (LOGP != 3 && LOGP != 6) begin : g_bad_logp
        $error("radix_8_ntt_ctrl: LOGP must be 3 or 6");
    end
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state_q, state_d;
    logic [GW-1:0] group_q, group_d;
    logic stage_q, stage_d;
    logic [1:0] drain_q, drain_d;
    logic v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [8*LOGP-1:0] idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d;
    logic [8*N-1:0] opa_q, opa_d, opt_q, opt_d, res_q, res_d, bf_y;
    int sh, off, base;
`ifdef BITREV_OUT_EN
    function automatic logic [LOGP-1:0] digit_rev(input logic [LOGP-1:0] v);
        logic [LOGP-1:0] r;
        r = '0;
        for (int d = 0; d < STAGES; d++) r[3*(STAGES-1-d) +: 3] = v[3*d +: 3];
        return r;
    endfunction
`endif
    radix_8_dif_ntt #(.N(N), .Q(Q), .W8(W8)) u_bf (.a(opa_q), .tf(opt_q), .y(bf_y));
    // sequencing: GROUPS issue cycles per stage, then a 3-cycle gap so the stage's writes land first
    always_comb begin
        state_d = state_q;
        group_d = group_q;
        stage_d = stage_q;
        drain_d = drain_q;
        busy = state_q == RUN || state_q == DRAIN;
        done = state_q == FIN;
        rd_en = state_q == RUN;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                group_d = '0;
                stage_d = 1'b0;
            end
            RUN: begin
                group_d = group_q + 1'b1;
                if (group_q == GW'(GROUPS - 1)) begin
                    state_d = DRAIN;
                    group_d = '0;
                    drain_d = 2'd0;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    drain_d = 2'd0;
                    state_d = stage_q == 1'(STAGES - 1) ? FIN : RUN;
                    stage_d = stage_q == 1'(STAGES - 1) ? stage_q : stage_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = 1'b0;
            end
        endcase
    end
    // element indices, twiddle exponents and write destinations for the current group
    always_comb begin
        rd_idx = '0;
        tf_exp = '0;
        idx0_d = '0;
        sh = LOGP - 3 * (int'(stage_q) + 1);
        off = int'(group_q) & ((1 << sh) - 1);
        base = ((int'(group_q) >> sh) << (sh + 3)) | off;
        for (int k = 0; k < 8; k++) begin
            rd_idx[k*LOGP +: LOGP] = rd_en ? LOGP'(base + (k << sh)) : '0;
            tf_exp[k*LOGP +: LOGP] = rd_en ? LOGP'((k * off) << (3 * int'(stage_q))) : '0;
`ifdef BITREV_OUT_EN
            idx0_d[k*LOGP +: LOGP] = stage_q == 1'(STAGES - 1) ? digit_rev(rd_idx[k*LOGP +: LOGP]) : rd_idx[k*LOGP +: LOGP];
`else
            idx0_d[k*LOGP +: LOGP] = rd_idx[k*LOGP +: LOGP];
`endif
        end
    end
    // 3-deep pipeline: request, operand capture, butterfly result
    always_comb begin
        v0_d = rd_en;
        v1_d = v0_q;
        idx1_d = idx0_q;
        opa_d = v0_q ? rd_data : opa_q;
        opt_d = v0_q ? tf_data : opt_q;
        v2_d = v1_q;
        idx2_d = idx1_q;
        res_d = v1_q ? bf_y : res_q;
    end
    // state and pipeline registers; reset aborts and discards in-flight groups
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            group_q <= '0;
            stage_q <= 1'b0;
            drain_q <= 2'd0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            idx0_q <= '0;
            idx1_q <= '0;
            idx2_q <= '0;
            opa_q <= '0;
            opt_q <= '0;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            group_q <= group_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
            v2_q <= v2_d;
            idx0_q <= idx0_d;
            idx1_q <= idx1_d;
            idx2_q <= idx2_d;
            opa_q <= opa_d;
            opt_q <= opt_d;
            res_q <= res_d;
        end
    end
    assign wr_en = v2_q;
    assign wr_idx = idx2_q;
    assign wr_data = res_q;
endmodule

// File: tb/tb_radix_8_ntt_ctrl.sv
// tb_radix_8_ntt_ctrl: randomized bench comparing the NTT sequencer against a direct O(P^2) transform model
module tb_radix_8_ntt_ctrl;
    localparam int N = 17, Q = 65537, LOGP = 6, P = 64;
    localparam longint OMEGA = 4080;
    logic clk = 0, rst = 1, start = 0, load = 0;
    logic busy, done, rd_en, wr_en;
    logic [8*LOGP-1:0] rd_idx, tf_exp, wr_idx;
    logic [8*N-1:0] rd_data = '0, tf_data = '0, wr_data;
    logic [N-1:0] mem [P];
    logic [N-1:0] init [P];
    longint pw [P];
    longint x [P];
    longint expm [P];
    int checks = 0, errors = 0;

    radix_8_ntt_ctrl #(.N(N), .Q(Q), .LOGP(LOGP)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
        .tf_exp(tf_exp), .tf_data(tf_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (rd_en) begin
                rd_data[k*N +: N] <= mem[rd_idx[k*LOGP +: LOGP]];
                tf_data[k*N +: N] <= N'(pw[tf_exp[k*LOGP +: LOGP]]);
            end
            if (wr_en) mem[wr_idx[k*LOGP +: LOGP]] <= wr_data[k*N +: N];
        end
        if (load) for (int i = 0; i < P; i++) mem[i] <= init[i];
    end

    function automatic void build_ref();
        longint s;
        for (int m = 0; m < P; m++) begin
            s = 0;
            for (int n = 0; n < P; n++) s = (s + x[n] * pw[(n * m) % P]) % Q;
`ifdef BITREV_OUT_EN
            expm[m] = s;
`else
            expm[8 * (m % 8) + m / 8] = s;
`endif
        end
    endfunction

    task automatic load_mem();
        for (int i = 0; i < P; i++) init[i] = N'(x[i]);
        @(negedge clk); load = 1;
        @(negedge clk); load = 0;
    endtask

    task automatic rand_x();
        for (int i = 0; i < P; i++) x[i] = longint'($urandom_range(Q - 1));
    endtask

    task automatic do_run(input int s1, input int s2, output int ndone, output int dcyc, output int d2cyc);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        ndone = 0; dcyc = -1; d2cyc = -1;
        for (int t = 0; t < 60; t++) begin
            if (done) begin
                ndone++;
                if (dcyc < 0) dcyc = t; else d2cyc = t;
            end
            start = (t == s1 || t == s2);
            @(negedge clk);
        end
        start = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        for (int t = 0; t < 30; t++) begin
            checks++;
            if ({busy, done, rd_en, wr_en} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d got busy/done/rd/wr=%b want 0000", t, {busy, done, rd_en, wr_en});
            end
            checks++;
            if (rd_idx !== '0 || tf_exp !== '0 || wr_idx !== '0 || wr_data !== '0) begin
                errors++;
                $display("FAIL reset_data cycle %0d got rd_idx=%h tf_exp=%h wr_idx=%h wr_data=%h want 0", t, rd_idx, tf_exp, wr_idx, wr_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_impulse_streams();
        logic [8*LOGP-1:0] ei, ee;
        int s, g, stride, off, base;
        logic ebusy, edone, erd, ewr;
        for (int i = 0; i < P; i++) x[i] = (i == 0) ? 1 : 0;
        load_mem();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int t = 0; t < 26; t++) begin
            ebusy = t < 22;
            edone = t == 22;
            erd = t < 22 && (t % 11) < 8;
            ewr = t < 22 && (t % 11) >= 3;
            checks++;
            if ({busy, done, rd_en, wr_en} !== {ebusy, edone, erd, ewr}) begin
                errors++;
                $display("FAIL stream_ctrl cycle %0d got busy/done/rd/wr=%b want %b", t, {busy, done, rd_en, wr_en}, {ebusy, edone, erd, ewr});
            end
            if (erd) begin
                s = t / 11; g = t % 11;
                stride = P >> (3 * (s + 1));
                off = g % stride;
                base = (g / stride) * 8 * stride + off;
                for (int k = 0; k < 8; k++) begin
                    ei[k*LOGP +: LOGP] = LOGP'(base + k * stride);
                    ee[k*LOGP +: LOGP] = LOGP'((k * off * (8 ** s)) % P);
                end
                checks++;
                if (rd_idx !== ei || tf_exp !== ee) begin
                    errors++;
                    $display("FAIL stream_addr cycle %0d got rd_idx=%h tf_exp=%h want %h %h", t, rd_idx, tf_exp, ei, ee);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < P; i++) begin
            checks++;
            if (mem[i] !== N'(1)) begin
                errors++;
                $display("FAIL impulse_data idx %0d got %0d want 1", i, mem[i]);
            end
        end
    endtask

    task automatic test_random();
        int nd, dc, d2;
        for (int r = 0; r < 2; r++) begin
            rand_x(); build_ref(); load_mem();
            do_run(-1, -1, nd, dc, d2);
            checks++;
            if (nd !== 1 || dc !== 22) begin
                errors++;
                $display("FAIL random_done got count=%0d cycle=%0d want 1 22", nd, dc);
            end
            for (int i = 0; i < P; i++) begin
                checks++;
                if (mem[i] !== N'(expm[i])) begin
                    errors++;
                    $display("FAIL random_data idx %0d got %0d want %0d", i, mem[i], expm[i]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int nd, dc, d2;
        rand_x(); build_ref(); load_mem();
        do_run(5, 22, nd, dc, d2);
        checks++;
        if (nd !== 1 || dc !== 22) begin
            errors++;
            $display("FAIL start_ignored got done count=%0d cycle=%0d want 1 22", nd, dc);
        end
        for (int i = 0; i < P; i++) begin
            checks++;
            if (mem[i] !== N'(expm[i])) begin
                errors++;
                $display("FAIL start_ignored_data idx %0d got %0d want %0d", i, mem[i], expm[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nd, dc, d2;
        rand_x(); load_mem();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        repeat (12) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int t = 13; t < 25; t++) begin
            checks++;
            if (wr_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid cycle %0d got wr_en=%b busy=%b want 0 0", t, wr_en, busy);
            end
            @(negedge clk);
        end
        rand_x(); build_ref(); load_mem();
        do_run(-1, -1, nd, dc, d2);
        checks++;
        if (nd !== 1 || dc !== 22) begin
            errors++;
            $display("FAIL reset_mid_done got count=%0d cycle=%0d want 1 22", nd, dc);
        end
        for (int i = 0; i < P; i++) begin
            checks++;
            if (mem[i] !== N'(expm[i])) begin
                errors++;
                $display("FAIL reset_mid_data idx %0d got %0d want %0d", i, mem[i], expm[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nd, dc, d2;
        rand_x(); load_mem();
        build_ref();
        for (int i = 0; i < P; i++) x[i] = expm[i];
        build_ref();
        do_run(23, -1, nd, dc, d2);
        checks++;
        if (nd !== 2 || dc !== 22 || d2 !== 46) begin
            errors++;
            $display("FAIL back_to_back got count=%0d cycles=%0d,%0d want 2 22,46", nd, dc, d2);
        end
        for (int i = 0; i < P; i++) begin
            checks++;
            if (mem[i] !== N'(expm[i])) begin
                errors++;
                $display("FAIL back_to_back_data idx %0d got %0d want %0d", i, mem[i], expm[i]);
            end
        end
    endtask

    initial begin
        pw[0] = 1;
        for (int i = 1; i < P; i++) pw[i] = (pw[i-1] * OMEGA) % Q;
        test_reset();
        test_impulse_streams();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
